eth_tx_arbiter: RTL and testbench
=================================

Name: eth_tx_arbiter

Overview:
Shares the single byte-write port of the Ethernet session buffer (data / wr / din / full) among N_CH capture channels. Grants one channel at a time in round-robin order and prefixes each burst with a 2-byte header (channel tag, per-channel sequence number). Streams the burst from the channel's show-ahead FIFO, then drops o_wr for a gap so the session closes the packet. Sits between the ADC/capture FIFOs and the Ethernet session block.

Parameters:
N_CH, 4, number of requesting channels (2..16)
LEN_W, 11, width of burst length field
MAX_BURST, 11'd1470, maximum body bytes; larger requests are clamped
GAP_CYCLES, 2, cycles o_wr is held low after a burst (>=1)
TIMEOUT, 16'd4096, body stall cycles (channel not valid) before abort

Ports:
i_clk  in  1  system clock
i_rst_n  in  1  asynchronous active-low reset
i_req  in  N_CH  per-channel burst request, level
i_len  in  N_CH*LEN_W  per-channel burst body length, sampled at grant
o_gnt  out  N_CH  one-hot grant, held for the whole burst including gap
i_ch_data  in  N_CH*8  per-channel FIFO head byte (show-ahead)
i_ch_valid  in  N_CH  per-channel FIFO not-empty
o_ch_rd  out  N_CH  per-channel FIFO pop strobe
o_data  out  8  byte to session
o_wr  out  1  burst-open level to session
o_din  out  1  byte-valid to session
i_full  in  1  session buffer full
o_busy  out  1  high in any state other than IDLE
o_err  out  N_CH  sticky per-channel timeout flag, cleared by reset only

Behaviour:
- Clock and reset: one clock, i_clk. Reset i_rst_n is asynchronous and active-low.
- Reset values: all outputs 0, state IDLE, round-robin pointer = N_CH-1 (channel 0 has first priority), sequence counters 0.
- Transfer rule: a byte is accepted iff o_wr & o_din & !i_full in the same cycle. o_din may be asserted while i_full is high; data must be held until accepted.
- States: IDLE, GRANT, HDR0, HDR1, BODY, GAP.
- IDLE: if any i_req bit is set, choose the first requester after the pointer (wrapping), register o_gnt, go to GRANT. Otherwise stay in IDLE.
- GRANT:
  - Latch len = min(i_len[g], MAX_BURST).
  - If len == 0: release the grant, pointer = g, return to IDLE. No bytes are emitted and seq is not incremented.
  - Otherwise assert o_wr and go to HDR0.
- HDR0: o_data = {4'hA, g[3:0]}, o_din = 1. On accept, go to HDR1.
- HDR1: o_data = seq[g], o_din = 1. On accept, go to BODY; clear the byte counter and stall counter.
- BODY:
  - o_data = i_ch_data[g] (combinational mux); o_din = i_ch_valid[g]; o_ch_rd[g] = accept.
  - On each accept the counter increments. When the counter reaches len-1 and that byte is accepted, increment seq[g] (8-bit wrap) and go to GAP.
  - Stall counter: increments when i_ch_valid[g] = 0 and clears on accept. When it reaches TIMEOUT-1, set o_err[g] and go to GAP. The short packet is sent as-is and seq is still incremented.
  - i_full stalls do not count toward the timeout.
- GAP: o_wr = 0, o_din = 0 for GAP_CYCLES cycles. Then o_gnt = 0, pointer = g, return to IDLE.
- Bursts longer than 1470 bytes are split into multiple PDUs by the session; the header appears only once, in the first PDU.
- i_req deasserting mid-burst is ignored; the burst completes. i_len changes after GRANT are ignored.
- Simultaneous requests: strict round-robin, so no channel is granted twice while another requester waits.
- Reset mid-burst: all outputs drop immediately. The session sees i_wr fall and closes any partial PDU; this is acceptable.
- Outputs other than o_data/o_din/o_ch_rd in BODY are registered.

Decomposition:
- Shared package: state encodings (one-hot, 6 bits), header tag constant 4'hA, MAX_BURST default.
- One sub-module: rr_arbiter (N_CH requests, pointer input, one-hot grant output, purely combinational priority rotate). The FSM, counters and seq registers stay in the top module.

Test Plan:
1. Single request: ch1 requests, len=4, FIFO holds 11 22 33 44, i_full=0. Required: session bytes A1 00 11 22 33 44; o_wr high 6 cycles then low for 2 cycles; seq[1] becomes 1; o_ch_rd[1] pulses exactly 4 times.
2. Round-robin: all 4 channels request continuously, len=1 each. Required grant order 0,1,2,3,0; no channel granted twice consecutively.
3. Backpressure: i_full held high for 5 cycles during HDR1, then again mid-BODY. Required: o_data stable while stalled; no lost or duplicated bytes; o_ch_rd only on accept; o_err stays 0.
4. Timeout: ch2 len=10, FIFO empties after 3 body bytes. Required: o_err[2] set after TIMEOUT stall cycles; 5 bytes total sent (2 header + 3 body); o_wr drops; arbiter returns to IDLE.
5. Edge lengths: len=0 produces no bytes, no seq change, and the grant is released in 2 cycles. len=2000 is clamped to 1470 body bytes.
6. Async reset mid-BODY: all outputs go to 0 immediately; the next request after reset is served starting at channel 0 with seq=0.

Source files
------------

// File: rtl/eth_tx_arbiter_pkg.sv
// Shared types and constants for the Ethernet TX channel arbiter.
package eth_tx_arbiter_pkg;

    typedef enum logic [5:0] {
        S_IDLE  = 6'b000001,
        S_GRANT = 6'b000010,
        S_HDR0  = 6'b000100,
        S_HDR1  = 6'b001000,
        S_BODY  = 6'b010000,
        S_GAP   = 6'b100000
    } state_t;

    localparam logic [3:0]  HDR_TAG       = 4'hA;
    localparam logic [10:0] MAX_BURST_DEF = 11'd1470;

endpackage

// File: rtl/eth_tx_arbiter_rr.sv
// Combinational round-robin pick: first requester strictly after ptr, wrapping.
module rr_arbiter #(
    parameter int unsigned N_CH  = 4,
    parameter int unsigned IDX_W = 2
) (
    input  logic [N_CH-1:0]  req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N_CH-1:0]  gnt,
    output logic [IDX_W-1:0] idx
);

    logic             found;
    logic [IDX_W-1:0] cand;

    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        cand  = '0;
        for (int unsigned i = 1; i <= N_CH; i++) begin
            cand = IDX_W'((32'(ptr) + i) % N_CH);
            if (!found && req[cand]) begin
                found     = 1'b1;
                gnt[cand] = 1'b1;
                idx       = cand;
            end
        end
    end

endmodule

// File: rtl/eth_tx_arbiter.sv
// Round-robin sharing of the session byte port among capture channels,
// with a tag/sequence header before each burst and a closing gap after it.
module eth_tx_arbiter
    import eth_tx_arbiter_pkg::*;
#(
    parameter int unsigned      N_CH       = 4,
    parameter int unsigned      LEN_W      = 11,
    parameter logic [LEN_W-1:0] MAX_BURST  = MAX_BURST_DEF,
    parameter int unsigned      GAP_CYCLES = 2,
    parameter logic [15:0]      TIMEOUT    = 16'd4096
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic [N_CH-1:0]       i_req,
    input  logic [N_CH*LEN_W-1:0] i_len,
    output logic [N_CH-1:0]       o_gnt,
    input  logic [N_CH*8-1:0]     i_ch_data,
    input  logic [N_CH-1:0]       i_ch_valid,
    output logic [N_CH-1:0]       o_ch_rd,
    output logic [7:0]            o_data,
    output logic                  o_wr,
    output logic                  o_din,
    input  logic                  i_full,
    output logic                  o_busy,
    output logic [N_CH-1:0]       o_err
);

    localparam int unsigned IDX_W = (N_CH > 2) ? $clog2(N_CH) : 1;

    state_t           state;
    logic [IDX_W-1:0] g, ptr, rr_idx;
    logic [N_CH-1:0]  rr_gnt;
    logic [LEN_W-1:0] len_q, cnt, len_g;
    logic [15:0]      stall, gap_cnt;
    logic [7:0]       seq [N_CH];
    logic [7:0]       data_q, ch_data;
    logic             din_q, ch_valid, in_body, accept;

    rr_arbiter #(
        .N_CH  (N_CH),
        .IDX_W (IDX_W)
    ) u_rr (
        .req (i_req),
        .ptr (ptr),
        .gnt (rr_gnt),
        .idx (rr_idx)
    );

    // Body bytes bypass the output register so the FIFO head streams at full rate.
    assign in_body  = (state == S_BODY);
    assign ch_valid = i_ch_valid[g];
    assign ch_data  = i_ch_data[g*8 +: 8];
    assign len_g    = i_len[g*LEN_W +: LEN_W];
    assign o_din    = in_body ? ch_valid : din_q;
    assign o_data   = in_body ? ch_data : data_q;
    assign accept   = o_wr & o_din & ~i_full;
    assign o_ch_rd  = (in_body && accept) ? o_gnt : '0;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state   <= S_IDLE;
            g       <= '0;
            ptr     <= IDX_W'(N_CH - 1);
            len_q   <= '0;
            cnt     <= '0;
            stall   <= '0;
            gap_cnt <= '0;
            data_q  <= '0;
            din_q   <= 1'b0;
            o_wr    <= 1'b0;
            o_gnt   <= '0;
            o_busy  <= 1'b0;
            o_err   <= '0;
            for (int unsigned i = 0; i < N_CH; i++) seq[i] <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (|i_req) begin
                        g      <= rr_idx;
                        o_gnt  <= rr_gnt;
                        o_busy <= 1'b1;
                        state  <= S_GRANT;
                    end
                end
                S_GRANT: begin
                    if (len_g == '0) begin
                        o_gnt  <= '0;
                        ptr    <= g;
                        o_busy <= 1'b0;
                        state  <= S_IDLE;
                    end else begin
                        len_q  <= (len_g > MAX_BURST) ? MAX_BURST : len_g;
                        o_wr   <= 1'b1;
                        din_q  <= 1'b1;
                        data_q <= {HDR_TAG, 4'(g)};
                        state  <= S_HDR0;
                    end
                end
                S_HDR0: begin
                    if (accept) begin
                        data_q <= seq[g];
                        state  <= S_HDR1;
                    end
                end
                S_HDR1: begin
                    if (accept) begin
                        din_q  <= 1'b0;
                        data_q <= '0;
                        cnt    <= '0;
                        stall  <= '0;
                        state  <= S_BODY;
                    end
                end
                S_BODY: begin
                    // A stall while the session is full leaves the timeout untouched.
                    if (accept) begin
                        stall <= '0;
                        if (cnt == len_q - LEN_W'(1)) begin
                            seq[g]  <= seq[g] + 8'd1;
                            o_wr    <= 1'b0;
                            gap_cnt <= '0;
                            state   <= S_GAP;
                        end else begin
                            cnt <= cnt + LEN_W'(1);
                        end
                    end else if (!ch_valid) begin
                        if (stall == TIMEOUT - 16'd1) begin
                            o_err[g] <= 1'b1;
                            seq[g]   <= seq[g] + 8'd1;
                            o_wr     <= 1'b0;
                            gap_cnt  <= '0;
                            state    <= S_GAP;
                        end else begin
                            stall <= stall + 16'd1;
                        end
                    end
                end
                S_GAP: begin
                    if (gap_cnt == 16'(GAP_CYCLES - 1)) begin
                        o_gnt  <= '0;
                        ptr    <= g;
                        o_busy <= 1'b0;
                        state  <= S_IDLE;
                    end else begin
                        gap_cnt <= gap_cnt + 16'd1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_eth_tx_arbiter.sv
// Directed bench for eth_tx_arbiter: FIFO/session models, hand-computed byte streams.
module tb_eth_tx_arbiter;

    localparam int N  = 4;
    localparam int LW = 11;
    localparam int TO = 32;

    logic              i_clk, i_rst_n, i_full;
    logic [N-1:0]      i_req, i_ch_valid, o_gnt, o_ch_rd, o_err;
    logic [N*LW-1:0]   i_len;
    logic [N*8-1:0]    i_ch_data;
    logic [7:0]        o_data;
    logic              o_wr, o_din, o_busy;

    eth_tx_arbiter #(
        .N_CH       (N),
        .LEN_W      (LW),
        .MAX_BURST  (11'd1470),
        .GAP_CYCLES (2),
        .TIMEOUT    (16'(TO))
    ) dut (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_req      (i_req),
        .i_len      (i_len),
        .o_gnt      (o_gnt),
        .i_ch_data  (i_ch_data),
        .i_ch_valid (i_ch_valid),
        .o_ch_rd    (o_ch_rd),
        .o_data     (o_data),
        .o_wr       (o_wr),
        .o_din      (o_din),
        .i_full     (i_full),
        .o_busy     (o_busy),
        .o_err      (o_err)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    byte unsigned fq [N][$];
    logic [7:0]   cap [$];
    int           gnt_log [$];
    int           full_mark [$];
    int           rd_cnt [N];
    int           n_chk, n_pass;
    int           burst_cnt, gnt_n, wr_n, gap_n, stall_n, hold_viol, rd_viol, full_left;
    int           stop_after;
    bit           seen_wr, hold_pend, auto_clr;
    logic         busy_s;
    logic [7:0]   hold_data;
    logic [N-1:0] prev_gnt;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [63:0] packq();
        logic [63:0] r = '0;
        foreach (cap[i]) r = {r[55:0], cap[i]};
        return r;
    endfunction

    task automatic begin_test();
        cap.delete();
        gnt_log.delete();
        full_mark.delete();
        for (int c = 0; c < N; c++) rd_cnt[c] = 0;
        burst_cnt = 0; gnt_n = 0; wr_n = 0; gap_n = 0; stall_n = 0;
        hold_viol = 0; rd_viol = 0; full_left = 0; hold_pend = 0; seen_wr = 0;
        auto_clr = 1; stop_after = 1000;
    endtask

    task automatic load(input int c, input int first, input int n);
        for (int k = 0; k < n; k++) fq[c].push_back(byte'((first + k) & 8'hFF));
    endtask

    task automatic set_len(input int c, input int v);
        i_len[c*LW +: LW] = LW'(v);
    endtask

    // One clock: drive inputs at the falling edge, sample 1 ns later, model the session and FIFOs.
    task automatic step();
        bit acc;
        if (full_left == 0 && full_mark.size() != 0) begin
            if (burst_cnt == full_mark[0]) begin
                full_left = 5;
                void'(full_mark.pop_front());
            end
        end
        i_full = (full_left != 0);
        for (int c = 0; c < N; c++) begin
            i_ch_valid[c]        = (fq[c].size() != 0);
            i_ch_data[c*8 +: 8]  = (fq[c].size() != 0) ? fq[c][0] : 8'h00;
        end
        #1;
        acc = o_wr & o_din & ~i_full;
        busy_s = o_busy;
        if (hold_pend && o_data !== hold_data) hold_viol++;
        hold_pend = o_wr & o_din & i_full;
        hold_data = o_data;
        if (o_gnt != 0 && prev_gnt == 0) begin
            for (int c = 0; c < N; c++) if (o_gnt[c]) gnt_log.push_back(c);
            burst_cnt = 0; seen_wr = 0; gap_n = 0; gnt_n = 0; stall_n = 0; wr_n = 0;
            if (auto_clr) i_req = i_req & ~o_gnt;
            if (gnt_log.size() >= stop_after) i_req = '0;
        end
        if (o_gnt != 0) gnt_n++;
        if (o_wr) begin
            seen_wr = 1;
            wr_n++;
        end else if (o_gnt != 0 && seen_wr) gap_n++;
        if (o_wr && !o_din) stall_n++;
        if (acc) begin
            cap.push_back(o_data);
            burst_cnt++;
        end
        if (o_ch_rd != 0 && !acc) rd_viol++;
        for (int c = 0; c < N; c++) begin
            if (o_ch_rd[c]) begin
                rd_cnt[c]++;
                if (fq[c].size() != 0) void'(fq[c].pop_front());
            end
        end
        if (full_left > 0) full_left--;
        prev_gnt = o_gnt;
        @(negedge i_clk);
    endtask

    task automatic run_burst(input string tag, input int max);
        bit started = 0;
        bit done = 0;
        for (int n = 0; n < max && !done; n++) begin
            step();
            if (busy_s) started = 1;
            else if (started) done = 1;
        end
        check({tag, "_done"}, 64'(done), 64'd1);
    endtask

    task automatic reset_pulse();
        i_rst_n = 1'b0;
        i_req = '0;
        for (int c = 0; c < N; c++) fq[c].delete();
        prev_gnt = '0;
        @(negedge i_clk);
        i_rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no_finish expected finish");
        $fatal(1);
    end

    initial begin
        bit reached;
        int dup;
        logic [19:0] order;
        n_chk = 0; n_pass = 0;
        i_rst_n = 1'b0; i_req = '0; i_len = '0; i_full = 1'b0;
        i_ch_data = '0; i_ch_valid = '0; prev_gnt = '0;
        begin_test();
        @(negedge i_clk);
        @(negedge i_clk);
        #1;
        check("reset_outs", {o_wr, o_din, o_busy, o_gnt, o_ch_rd, o_err, o_data}, 64'd0);
        @(negedge i_clk);
        i_rst_n = 1'b1;

        // Single request on ch1
        begin_test();
        load(1, 8'h11, 0);
        fq[1].push_back(8'h11); fq[1].push_back(8'h22);
        fq[1].push_back(8'h33); fq[1].push_back(8'h44);
        set_len(1, 4);
        i_req = 4'b0010;
        run_burst("t1", 30);
        check("t1_bytes", packq(), 64'hA1_00_11_22_33_44);
        check("t1_nbytes", 64'(cap.size()), 64'd6);
        check("t1_wr_high", 64'(wr_n), 64'd6);
        check("t1_gap_low", 64'(gap_n), 64'd2);
        check("t1_rd_cnt", 64'(rd_cnt[1]), 64'd4);
        begin_test();
        fq[1].push_back(8'h55);
        set_len(1, 1);
        i_req = 4'b0010;
        run_burst("t1b", 20);
        check("t1_seq_next", packq(), 64'hA1_01_55);

        // Round-robin with all channels requesting
        reset_pulse();
        begin_test();
        auto_clr = 0; stop_after = 5;
        fq[0].push_back(8'h01); fq[0].push_back(8'h02);
        fq[1].push_back(8'h11); fq[2].push_back(8'h21); fq[3].push_back(8'h31);
        for (int c = 0; c < N; c++) set_len(c, 1);
        i_req = 4'b1111;
        for (int k = 0; k < 5; k++) run_burst("t2", 20);
        order = '0;
        dup = 0;
        foreach (gnt_log[i]) begin
            order = {order[15:0], 4'(gnt_log[i])};
            if (i > 0 && gnt_log[i] == gnt_log[i-1]) dup++;
        end
        check("t2_order", 64'(order), 64'h01230);
        check("t2_ngrants", 64'(gnt_log.size()), 64'd5);
        check("t2_no_repeat", 64'(dup), 64'd0);
        check("t2_nbytes", 64'(cap.size()), 64'd15);
        check("t2_first", {cap[0], cap[1], cap[2]}, 64'hA0_00_01);
        check("t2_fifth", {cap[12], cap[13], cap[14]}, 64'hA0_01_02);

        // Backpressure in HDR1 and mid-body
        begin_test();
        load(3, 8'h31, 6);
        set_len(3, 6);
        full_mark.push_back(1);
        full_mark.push_back(4);
        i_req = 4'b1000;
        run_burst("t3", 60);
        check("t3_bytes", packq(), 64'hA3_01_31_32_33_34_35_36);
        check("t3_wr_high", 64'(wr_n), 64'd18);
        check("t3_hold", 64'(hold_viol), 64'd0);
        check("t3_rd_only_acc", 64'(rd_viol), 64'd0);
        check("t3_rd_cnt", 64'(rd_cnt[3]), 64'd6);
        check("t3_err", 64'(o_err), 64'd0);

        // Body stall timeout on ch2
        begin_test();
        load(2, 8'h21, 3);
        set_len(2, 10);
        i_req = 4'b0100;
        run_burst("t4", TO + 40);
        check("t4_bytes", packq(), 64'hA2_01_21_22_23);
        check("t4_nbytes", 64'(cap.size()), 64'd5);
        check("t4_stall_cycles", 64'(stall_n), 64'(TO));
        check("t4_err", 64'(o_err), 64'b0100);
        check("t4_wr_low", 64'(o_wr), 64'd0);

        // Zero length, then clamp
        begin_test();
        set_len(0, 0);
        i_req = 4'b0001;
        run_burst("t5z", 10);
        check("t5_zero_nbytes", 64'(cap.size()), 64'd0);
        check("t5_zero_gnt_cycles", 64'(gnt_n), 64'd1);
        check("t5_zero_granted", 64'(gnt_log.size()), 64'd1);
        begin_test();
        fq[0].push_back(8'h5A);
        set_len(0, 1);
        i_req = 4'b0001;
        run_burst("t5s", 20);
        check("t5_seq_kept", packq(), 64'hA0_02_5A);
        begin_test();
        load(1, 0, 1500);
        set_len(1, 2000);
        i_req = 4'b0010;
        run_burst("t5c", 1600);
        check("t5_clamp_nbytes", 64'(cap.size()), 64'd1472);
        check("t5_clamp_rd", 64'(rd_cnt[1]), 64'd1470);
        check("t5_clamp_last", 64'(cap[cap.size()-1]), 64'hBD);
        fq[1].delete();

        // Asynchronous reset in the middle of a body
        begin_test();
        load(3, 8'h40, 8);
        set_len(3, 8);
        i_req = 4'b1000;
        reached = 0;
        for (int n = 0; n < 40 && !reached; n++) begin
            step();
            if (burst_cnt >= 4) reached = 1;
        end
        check("t6_in_body", 64'(reached), 64'd1);
        check("t6_err_sticky", 64'(o_err), 64'b0100);
        #3 i_rst_n = 1'b0;
        #1;
        check("t6_reset_outs", {o_wr, o_din, o_busy, o_gnt, o_ch_rd, o_err, o_data}, 64'd0);
        i_req = '0;
        for (int c = 0; c < N; c++) fq[c].delete();
        prev_gnt = '0;
        @(negedge i_clk);
        i_rst_n = 1'b1;
        begin_test();
        fq[0].push_back(8'h77);
        fq[2].push_back(8'h88);
        set_len(0, 1);
        set_len(2, 1);
        i_req = 4'b0101;
        run_burst("t6a", 20);
        run_burst("t6b", 20);
        check("t6_after_reset", packq(), 64'hA0_00_77_A2_00_88);
        check("t6_first_gnt", 64'(gnt_log[0]), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
